cc_seq_ctrl: RTL and testbench
==============================

Name: cc_seq_ctrl

Overview:
- Sequential controller for the score-classification datapath: accepts 7 four-bit scores serially with per-job options (opt, a, b).
- Sorts score IDs with one odd-even transposition pass per cycle, running in parallel with a per-element pass/fail count.
- Streams the 7 sorted IDs out under a valid/ready handshake, with the pass count held alongside.
- Replaces the fully parallel combinational classifier where area matters; one job in flight at a time.

Parameters:
- NUM_SCORE, 7, number of scores per job; fixed at 7, which sets the 3-bit ID width. Other values are unsupported.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  score beat valid.
- in_ready  out  1  controller can accept a beat.
- in_score  in  4  score; two's complement when opt[0]=1.
- opt  in  3  [0] signed mode, [1] descending sort, [2] output fail count instead of pass count. Sampled on beat 0.
- a  in  2  scale factor, sampled on beat 0.
- b  in  3  offset, sampled on beat 0.
- out_valid  out  1  out_id/out_cnt valid.
- out_ready  in  1  downstream accepts the beat.
- out_id  out  3  sorted ID; beat k carries rank k.
- out_cnt  out  3  pass/fail count; constant for all 7 beats of a job.
- busy  out  1  high in SORT and OUT.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, out_id=0, out_cnt=0, busy=0.
- Reset mid-operation: aborts the job immediately, discards all stored data, same values as at reset.
- States:
  - IDLE/LOAD: in_ready=1. Each cycle with in_valid=1 is a beat. Beat k stores score k with ID k and adds it into the sum register. Gaps in in_valid are allowed.
  - opt/a/b are latched only on beat 0.
  - The 7th accepted beat (edge T) moves to SORT.
  - SORT: cycles T+1..T+7, in_ready=0, busy=1, in_valid ignored.
    - Pass p (0..6): even p compare-exchanges pairs (0,1)(2,3)(4,5); odd p compares (1,2)(3,4)(5,6).
    - Concurrently, element p is transformed and compared against the threshold; the counter increments on pass.
  - OUT: out_valid=1 from cycle T+8.
    - The beat index advances only on out_valid&&out_ready. out_id/out_cnt are held stable while out_ready=0.
    - After beat 6 is accepted: next cycle goes to IDLE with out_valid=0 and in_ready=1.
    - Minimum job latency: 7th input beat to 1st output beat is 8 cycles.
- Value interpretation: opt[0]=0 means unsigned 0..15; opt[0]=1 means signed -8..7, sign-extended.
- Sort order:
  - opt[1]=0: ascending by value.
  - opt[1]=1: descending by value.
  - Ties: lower ID ranks first in both orders.
- Arithmetic (8-bit signed internal):
  - sum = sum of the 7 values.
  - avg = sum/7, truncated toward zero.
  - thr = avg - a.
  - tr(s) = s/(a+1)+b when s<0 (truncate toward zero); otherwise s*(a+1)+b.
  - Pass when tr >= thr. c = number of passes.
  - out_cnt = opt[2] ? 7-c : c.
- Simultaneous events:
  - in_valid during SORT/OUT is ignored and not buffered.
  - rst has priority over everything.

Test Plan:
- Basic ascending: opt=000, a=0, b=0, scores 0,1,2,3,4,5,6 back-to-back -> out_id 0,1,2,3,4,5,6. out_cnt=4 (thr=3). First out_valid 8 cycles after the last input.
- Descending with ties: opt=010, a=1, b=2, scores 5,5,9,1,9,0,3 -> out_id 2,4,0,1,6,3,5. out_cnt=6 (thr=3; only score 0 fails, tr=2).
- Signed with fail count: opt=101, a=3, b=0, scores F,8,7,0,2,E,1 (hex) -> out_id 1,5,0,3,6,4,2. out_cnt=0 (all 7 pass with thr=-3).
- Back-pressure: during test 1, hold out_ready=0 for 3 cycles at beat 2 -> out_id stays 2 and out_valid stays 1. Sequence completes unchanged and no beat is lost or duplicated.
- Input gaps and busy drop: insert 2 idle cycles between beats 3 and 4, and drive in_valid during SORT -> results identical to the gapless run. in_ready=0 and extra beats ignored.
- Mid-job reset: assert rst in the 3rd SORT cycle -> next cycle in_ready=1, out_valid=0, out_cnt=0. A new job then runs to the correct result with no residue from the aborted job.

Source files
------------

// File: rtl/cc_seq_ctrl.sv
// Serial score-classification controller: loads 7 scores, sorts their IDs with one
// odd-even transposition pass per cycle while counting passes, then streams the ranking.
module cc_seq_ctrl #(
   parameter int NUM_SCORE = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_score,
   input  logic [2:0] opt,
   input  logic [1:0] a,
   input  logic [2:0] b,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [2:0] out_id,
   output logic [2:0] out_cnt,
   output logic       busy
);

   localparam logic [2:0] LAST_IDX = 3'(NUM_SCORE - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SORT = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t            state_r, state_s;
   logic        [2:0] idx_r;
   logic signed [7:0] val_r [0:NUM_SCORE-1];
   logic        [2:0] id_r  [0:NUM_SCORE-1];
   logic        [2:0] id_s  [0:NUM_SCORE-1];
   logic signed [7:0] sum_r;
   logic        [2:0] cnt_r;
   logic        [2:0] opt_r;
   logic        [1:0] a_r;
   logic        [2:0] b_r;
   logic              in_ready_r, out_valid_r, busy_r;
   logic        [2:0] out_id_r, out_cnt_r;

   logic [NUM_SCORE-2:0] swap_s;
   logic signed [7:0]    scale_s, offs_s, avg_s, thr_s, cur_s, tr_s, beat_val_s;
   logic                 pass_s;
   logic        [2:0]    cnt_fin_s;

   function automatic logic signed [7:0] to_val(input logic [3:0] s, input logic sgn);
      logic signed [7:0] v;
      if (sgn) begin
         v = {{4{s[3]}}, s};
      end else begin
         v = {4'b0000, s};
      end
      return v;
   endfunction

   // Total order used by the sorter: by value in the requested direction, ties by lower ID.
   function automatic logic ranks_before(input logic signed [7:0] vx, input logic [2:0] ix,
                                         input logic signed [7:0] vy, input logic [2:0] iy,
                                         input logic desc);
      logic r;
      if (vx == vy) begin
         r = (ix < iy);
      end else if (desc) begin
         r = (vx > vy);
      end else begin
         r = (vx < vy);
      end
      return r;
   endfunction

   // Swap decisions for the current pass; even passes use pairs starting at 0, odd at 1.
   always_comb begin
      for (int j = 0; j < NUM_SCORE - 1; j++) begin
         swap_s[j] = (state_r == S_SORT) && (j[0] == idx_r[0]) &&
                     ranks_before(val_r[id_r[j+1]], id_r[j+1], val_r[id_r[j]], id_r[j], opt_r[1]);
      end
   end

   // Apply the disjoint compare-exchanges to the ID array.
   always_comb begin
      id_s[0] = swap_s[0] ? id_r[1] : id_r[0];
      for (int k = 1; k < NUM_SCORE - 1; k++) begin
         id_s[k] = swap_s[k] ? id_r[k+1] : (swap_s[k-1] ? id_r[k-1] : id_r[k]);
      end
      id_s[NUM_SCORE-1] = swap_s[NUM_SCORE-2] ? id_r[NUM_SCORE-2] : id_r[NUM_SCORE-1];
   end

   // Threshold and per-element transform; values are indexed by original ID so each counts once.
   always_comb begin
      scale_s = $signed({6'b000000, a_r}) + 8'sd1;
      offs_s  = $signed({5'b00000, b_r});
      avg_s   = sum_r / 8'sd7;
      thr_s   = avg_s - $signed({6'b000000, a_r});
      cur_s   = val_r[idx_r];
      if (cur_s < 8'sd0) begin
         tr_s = (cur_s / scale_s) + offs_s;
      end else begin
         tr_s = (cur_s * scale_s) + offs_s;
      end
      pass_s     = (tr_s >= thr_s);
      cnt_fin_s  = cnt_r + {2'b00, pass_s};
      beat_val_s = to_val(in_score, (idx_r == 3'd0) ? opt[0] : opt_r[0]);
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (in_valid && (idx_r == LAST_IDX)) begin
               state_s = S_SORT;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_SORT: begin
            if (idx_r == LAST_IDX) begin
               state_s = S_OUT;
            end else begin
               state_s = S_SORT;
            end
         end
         S_OUT: begin
            if (out_valid_r && out_ready && (idx_r == LAST_IDX)) begin
               state_s = S_IDLE;
            end else begin
               state_s = S_OUT;
            end
         end
         default: state_s = S_IDLE;
      endcase
   end

   // State, datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= S_IDLE;
         idx_r       <= 3'd0;
         sum_r       <= 8'sd0;
         cnt_r       <= 3'd0;
         opt_r       <= 3'd0;
         a_r         <= 2'd0;
         b_r         <= 3'd0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         out_id_r    <= 3'd0;
         out_cnt_r   <= 3'd0;
         for (int k = 0; k < NUM_SCORE; k++) begin
            val_r[k] <= 8'sd0;
            id_r[k]  <= 3'd0;
         end
      end else begin
         state_r     <= state_s;
         in_ready_r  <= (state_s == S_IDLE);
         out_valid_r <= (state_s == S_OUT);
         busy_r      <= (state_s != S_IDLE);
         case (state_r)
            S_IDLE: begin
               if (in_valid) begin
                  val_r[idx_r] <= beat_val_s;
                  id_r[idx_r]  <= idx_r;
                  idx_r        <= (idx_r == LAST_IDX) ? 3'd0 : idx_r + 3'd1;
                  if (idx_r == 3'd0) begin
                     opt_r <= opt;
                     a_r   <= a;
                     b_r   <= b;
                     sum_r <= beat_val_s;
                     cnt_r <= 3'd0;
                  end else begin
                     sum_r <= sum_r + beat_val_s;
                  end
               end
            end
            S_SORT: begin
               id_r  <= id_s;
               cnt_r <= cnt_fin_s;
               idx_r <= (idx_r == LAST_IDX) ? 3'd0 : idx_r + 3'd1;
               if (idx_r == LAST_IDX) begin
                  out_id_r  <= id_s[0];
                  out_cnt_r <= opt_r[2] ? (3'd7 - cnt_fin_s) : cnt_fin_s;
               end
            end
            S_OUT: begin
               if (out_valid_r && out_ready) begin
                  idx_r <= (idx_r == LAST_IDX) ? 3'd0 : idx_r + 3'd1;
                  if (idx_r != LAST_IDX) begin
                     out_id_r <= id_r[idx_r + 3'd1];
                  end
               end
            end
            default: idx_r <= 3'd0;
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign out_id    = out_id_r;
   assign out_cnt   = out_cnt_r;

endmodule

// File: tb/tb_cc_seq_ctrl.sv
// Self-checking bench for cc_seq_ctrl: directed scenarios plus randomized jobs checked
// against a behavioural model (selection sort + plain integer arithmetic).
module tb_cc_seq_ctrl;

   typedef logic [3:0] sc_t [7];
   typedef logic [2:0] id_arr_t [7];

   logic       clk = 1'b0;
   logic       rst, in_valid, in_ready, out_valid, out_ready, busy;
   logic [3:0] in_score;
   logic [2:0] opt, b, out_id, out_cnt;
   logic [1:0] a;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   cc_seq_ctrl dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_score(in_score),
      .opt(opt), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .out_id(out_id), .out_cnt(out_cnt), .busy(busy)
   );

   // Reference: values from the spec's rules, ranking by repeated best-pick.
   task automatic model(input sc_t sc, input logic [2:0] o, input logic [1:0] aa,
                        input logic [2:0] bb, output id_arr_t eids, output logic [2:0] ecnt);
      int v [7];
      bit used [7];
      int sum, avg, thr, tr, c, best;
      sum = 0;
      for (int k = 0; k < 7; k++) begin
         v[k] = int'(sc[k]);
         if (o[0] && v[k] >= 8) v[k] = v[k] - 16;
         sum += v[k];
         used[k] = 1'b0;
      end
      avg = sum / 7;
      thr = avg - int'(aa);
      c = 0;
      for (int k = 0; k < 7; k++) begin
         if (v[k] < 0) tr = v[k] / (int'(aa) + 1) + int'(bb);
         else tr = v[k] * (int'(aa) + 1) + int'(bb);
         if (tr >= thr) c++;
      end
      ecnt = o[2] ? 3'(7 - c) : 3'(c);
      for (int r = 0; r < 7; r++) begin
         best = -1;
         for (int k = 0; k < 7; k++) begin
            if (!used[k]) begin
               if (best < 0) best = k;
               else if (v[k] != v[best] && (o[1] ? (v[k] > v[best]) : (v[k] < v[best]))) best = k;
            end
         end
         used[best] = 1'b1;
         eids[r] = 3'(best);
      end
   endtask

   // Drive 7 beats starting at the current negedge; options are garbage on beats 1..6.
   task automatic send_job(input sc_t sc, input logic [2:0] o, input logic [1:0] aa,
                           input logic [2:0] bb, input int gap_after, input int gap_len,
                           input bit drive_sort);
      for (int k = 0; k < 7; k++) begin
         in_valid = 1'b1;
         in_score = sc[k];
         if (k == 0) begin
            opt = o; a = aa; b = bb;
         end else begin
            opt = 3'($urandom); a = 2'($urandom); b = 3'($urandom);
         end
         @(negedge clk);
         if (k == gap_after) begin
            in_valid = 1'b0;
            in_score = 4'($urandom);
            repeat (gap_len) @(negedge clk);
         end
      end
      in_valid = drive_sort;
      in_score = 4'($urandom);
   endtask

   task automatic run_and_check_job(input string name, input sc_t sc, input logic [2:0] o,
                                    input logic [1:0] aa, input logic [2:0] bb,
                                    input id_arr_t eids, input logic [2:0] ecnt,
                                    input int gap_after, input int gap_len, input bit drive_sort,
                                    input int bp_beat, input int bp_len, input bit rand_bp);
      int lat, stall;
      bit sort_ok, hold_ok;
      id_arr_t got_id, got_cnt;
      logic [2:0] held;
      sort_ok = 1'b1;
      hold_ok = 1'b1;
      out_ready = 1'b0;
      send_job(sc, o, aa, bb, gap_after, gap_len, drive_sort);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 40) begin
         if (in_ready !== 1'b0 || busy !== 1'b1) sort_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      total++;
      if (lat != 8) begin
         bad++;
         $display("FAIL %s latency: got %0d cycles, want 8", name, lat);
      end
      total++;
      if (!sort_ok) begin
         bad++;
         $display("FAIL %s sort_phase: in_ready/busy not 0/1 while sorting", name);
      end
      for (int k = 0; k < 7; k++) begin
         stall = (k == bp_beat) ? bp_len : (rand_bp ? int'($urandom_range(0, 2)) : 0);
         held = out_id;
         out_ready = 1'b0;
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_id !== held) hold_ok = 1'b0;
         end
         if (out_valid !== 1'b1) hold_ok = 1'b0;
         got_id[k] = out_id;
         got_cnt[k] = out_cnt;
         out_ready = 1'b1;
         @(negedge clk);
      end
      out_ready = 1'b0;
      for (int k = 0; k < 7; k++) begin
         total++;
         if (got_id[k] !== eids[k]) begin
            bad++;
            $display("FAIL %s out_id[%0d]: got %0d, want %0d", name, k, got_id[k], eids[k]);
         end
         total++;
         if (got_cnt[k] !== ecnt) begin
            bad++;
            $display("FAIL %s out_cnt[%0d]: got %0d, want %0d", name, k, got_cnt[k], ecnt);
         end
      end
      total++;
      if (!hold_ok) begin
         bad++;
         $display("FAIL %s hold: out_valid/out_id changed or dropped under back-pressure", name);
      end
      total++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
         bad++;
         $display("FAIL %s end_state: got valid/ready/busy=%b, want 010", name,
                  {out_valid, in_ready, busy});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_score = 4'd0; opt = 3'd0; a = 2'd0; b = 3'd0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         bad++;
         $display("FAIL reset_ctrl: got ready/valid/busy=%b, want 100", {in_ready, out_valid, busy});
      end
      total++;
      if ({out_id, out_cnt} !== 6'd0) begin
         bad++;
         $display("FAIL reset_data: got id=%0d cnt=%0d, want 0 0", out_id, out_cnt);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      sc_t sc;
      id_arr_t e;
      sc = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
      e = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
      run_and_check_job("basic", sc, 3'b000, 2'd0, 3'd0, e, 3'd4, -1, 0, 1'b0, -1, 0, 1'b0);
      run_and_check_job("backpressure", sc, 3'b000, 2'd0, 3'd0, e, 3'd4, -1, 0, 1'b0, 2, 3, 1'b0);
   endtask

   task automatic test_desc_ties();
      sc_t sc;
      id_arr_t e;
      sc = '{4'd5, 4'd5, 4'd9, 4'd1, 4'd9, 4'd0, 4'd3};
      e = '{3'd2, 3'd4, 3'd0, 3'd1, 3'd6, 3'd3, 3'd5};
      run_and_check_job("desc_ties", sc, 3'b010, 2'd1, 3'd2, e, 3'd6, -1, 0, 1'b0, -1, 0, 1'b0);
   endtask

   task automatic test_signed_fail();
      sc_t sc;
      id_arr_t e;
      sc = '{4'hF, 4'h8, 4'h7, 4'h0, 4'h2, 4'hE, 4'h1};
      e = '{3'd1, 3'd5, 3'd0, 3'd3, 3'd6, 3'd4, 3'd2};
      run_and_check_job("signed_fail", sc, 3'b101, 2'd3, 3'd0, e, 3'd0, -1, 0, 1'b0, -1, 0, 1'b0);
   endtask

   task automatic test_gaps();
      sc_t sc;
      id_arr_t e;
      sc = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
      e = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
      run_and_check_job("gaps", sc, 3'b000, 2'd0, 3'd0, e, 3'd4, 3, 2, 1'b1, -1, 0, 1'b0);
   endtask

   task automatic test_mid_reset();
      sc_t sc;
      id_arr_t e;
      sc = '{4'd5, 4'd5, 4'd9, 4'd1, 4'd9, 4'd0, 4'd3};
      send_job(sc, 3'b010, 2'd1, 3'd2, -1, 0, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if ({in_ready, out_valid, busy, out_cnt} !== 6'b100_000) begin
         bad++;
         $display("FAIL mid_reset: got ready/valid/busy=%b cnt=%0d, want 100 0",
                  {in_ready, out_valid, busy}, out_cnt);
      end
      sc = '{4'hF, 4'h8, 4'h7, 4'h0, 4'h2, 4'hE, 4'h1};
      e = '{3'd1, 3'd5, 3'd0, 3'd3, 3'd6, 3'd4, 3'd2};
      run_and_check_job("after_reset", sc, 3'b101, 2'd3, 3'd0, e, 3'd0, -1, 0, 1'b0, -1, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      sc_t sc;
      id_arr_t e;
      sc = '{4'd5, 4'd5, 4'd9, 4'd1, 4'd9, 4'd0, 4'd3};
      e = '{3'd2, 3'd4, 3'd0, 3'd1, 3'd6, 3'd3, 3'd5};
      run_and_check_job("b2b_first", sc, 3'b010, 2'd1, 3'd2, e, 3'd6, -1, 0, 1'b0, -1, 0, 1'b0);
      sc = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
      e = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
      run_and_check_job("b2b_second", sc, 3'b000, 2'd0, 3'd0, e, 3'd4, -1, 0, 1'b0, -1, 0, 1'b0);
   endtask

   task automatic test_random();
      sc_t sc;
      id_arr_t e;
      logic [2:0] ecnt, o, bb;
      logic [1:0] aa;
      for (int n = 0; n < 30; n++) begin
         for (int k = 0; k < 7; k++) sc[k] = 4'($urandom);
         if (n % 5 == 0) begin
            for (int k = 1; k < 7; k++) sc[k] = sc[0];
         end
         o = 3'($urandom);
         aa = 2'($urandom);
         bb = 3'($urandom);
         model(sc, o, aa, bb, e, ecnt);
         run_and_check_job($sformatf("random%0d", n), sc, o, aa, bb, e, ecnt,
                           int'($urandom_range(0, 6)) - 1, int'($urandom_range(1, 3)),
                           1'($urandom), int'($urandom_range(0, 6)),
                           int'($urandom_range(0, 3)), 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_desc_ties();
      test_signed_fail();
      test_gaps();
      test_mid_reset();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
